// File: rtl/i2s_mic_rx_pkg.sv
// Shared constants, state encoding and frame helpers for the I2S microphone receiver.
// The frame is two 32-bit slots, and word select is high for bit positions 31..62.
package i2s_mic_rx_pkg;

  localparam int SLOT_BITS      = 32;
  localparam int FRAME_BITS     = 64;
  localparam int DATA_W_DEFAULT = 18;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ws leads each slot MSB by one bit: high for b=31..62, low otherwise
  function automatic logic ws_for_bit(input logic [5:0] b);
    return (b >= 6'(SLOT_BITS - 1)) && (b <= 6'(FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_mic_rx_sck.sv
// Bit-clock generator: divides clk into ada_sck and emits the strobes the receiver uses.
// The last cycle of the high phase is also the edge where sck falls, so both strobes coincide.
module i2s_sck_gen
  import i2s_mic_rx_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic sck_rise_last,
  output logic sck_fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;
  logic       sck_r;
  logic       tick_s;

  assign tick_s = run && (cnt_r == LAST);

  // Half-period divider; held at zero with sck low whenever not running
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'd0;
      sck_r <= 1'b0;
    end else if (!run) begin
      cnt_r <= 8'd0;
      sck_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= 8'd0;
      sck_r <= ~sck_r;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign sck           = sck_r;
  assign sck_rise_last = tick_s && sck_r;
  assign sck_fall      = tick_s && sck_r;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: drives sck/ws, captures the left slot MSB first and
// presents it through a one-deep holding register with a sticky overrun flag.
module i2s_mic_rx
  import i2s_mic_rx_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              ada_sck,
  output logic              ada_ws,
  input  logic              ada_sd,
  output logic              ada_lrs,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  state_t              state_r, state_next_s;
  logic                run_s, sck_s, sck_rise_last_s, sck_fall_s;
  logic                sd_meta_r, sd_sync_r;
  logic [5:0]          bit_r;
  logic                ws_r, done_r;
  logic [DATA_W-1:0]   shift_r, sample_r;
  logic                valid_r, overrun_r;
  logic                in_data_s, last_bit_s, accept_s, drop_s;

  assign run_s = (state_r == RUN);

  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk          (clk),
    .rst          (rst),
    .run          (run_s),
    .sck          (sck_s),
    .sck_rise_last(sck_rise_last_s),
    .sck_fall     (sck_fall_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (en) state_next_s = RUN;  else state_next_s = IDLE;
      RUN:     if (!en) state_next_s = IDLE; else state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // Two-flop synchronizer for the asynchronous mic data
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_meta_r <= 1'b0;
      sd_sync_r <= 1'b0;
    end else begin
      sd_meta_r <= ada_sd;
      sd_sync_r <= sd_meta_r;
    end
  end

  assign in_data_s  = (int'(bit_r) < DATA_W);
  assign last_bit_s = (int'(bit_r) == DATA_W - 1);

  // Bit position, word select and left-slot shift register; idle parks at b=63
  always_ff @(posedge clk) begin
    if (rst || !run_s) begin
      bit_r   <= 6'd63;
      ws_r    <= 1'b0;
      shift_r <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= sck_rise_last_s && last_bit_s;
      if (sck_rise_last_s && in_data_s) begin
        shift_r <= {shift_r[DATA_W-2:0], sd_sync_r};
      end
      if (sck_fall_s) begin
        bit_r <= bit_r + 6'd1;
        ws_r  <= ws_for_bit(bit_r + 6'd1);
      end
    end
  end

  assign accept_s = done_r && (!valid_r || sample_ready);
  assign drop_s   = done_r && valid_r && !sample_ready;

  // Holding register, valid handshake and sticky overrun (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r  <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (accept_s) begin
        sample_r <= shift_r;
        valid_r  <= 1'b1;
      end else if (valid_r && sample_ready) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign ada_sck      = sck_s;
  assign ada_ws       = ws_r;
  assign ada_lrs      = 1'b0;
  assign sample       = sample_r;
  assign sample_valid = valid_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Self-checking bench for i2s_mic_rx: an I2S mic model follows the DUT's sck/ws and
// serves left words from a table; results are checked against that table.
module tb_i2s_mic_rx;

  localparam int CLK_DIV = 8;
  localparam int DATA_W  = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic ada_sck, ada_ws, ada_lrs;
  logic ada_sd = 1'b0;
  logic [DATA_W-1:0] sample;
  logic sample_valid, overrun;
  logic sample_ready = 1'b0;
  logic overrun_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  i2s_mic_rx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ada_sck(ada_sck), .ada_ws(ada_ws), .ada_sd(ada_sd), .ada_lrs(ada_lrs),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // Mic model: new bit after each sck fall; a ws change starts the one-bit lead-in of a slot
  logic [DATA_W-1:0] left_words [64];
  logic [DATA_W-1:0] right_word = 18'h15A5C;
  logic [DATA_W-1:0] cur_left = '0;
  int word_idx = 0;
  int pos = -1;
  logic slot_right = 1'b0;
  logic sck_prev = 1'b0;
  logic ws_prev = 1'b0;

  always @(negedge clk) begin
    if (rst || !en) begin
      pos = -1;
      slot_right = 1'b0;
      ada_sd = 1'b0;
    end else if (sck_prev && !ada_sck) begin
      if (ada_ws !== ws_prev) begin
        pos = -1;
        slot_right = ada_ws;
      end else begin
        pos = pos + 1;
      end
      if (!slot_right && pos == 0) begin
        cur_left = left_words[word_idx % 64];
        word_idx = word_idx + 1;
      end
      if (pos >= 0 && pos < DATA_W)
        ada_sd = slot_right ? right_word[DATA_W-1-pos] : cur_left[DATA_W-1-pos];
      else
        ada_sd = 1'($urandom);
    end
    sck_prev = ada_sck;
    ws_prev = ada_ws;
  end

  // Handshake log
  logic [DATA_W-1:0] got_q [$];
  int got_cyc [$];
  always @(negedge clk) begin
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      got_q.push_back(sample);
      got_cyc.push_back(cyc);
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 64; i++) left_words[i] = 18'h0;
    rst = 1'b1; en = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ada_sck, ada_ws, ada_lrs, sample_valid, overrun} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got sck/ws/lrs/valid/ovr=%b expected 00000",
               {ada_sck, ada_ws, ada_lrs, sample_valid, overrun});
    end
    n_checks++;
    if (sample !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_sample: got %h expected 00000", sample);
    end
  endtask

  task automatic test_waveform();
    int last_rise = -1;
    int falls = 0;
    logic ps, pw;
    sample_ready = 1'b1;
    for (int i = 0; i < 8; i++) left_words[(word_idx + i) % 64] = DATA_W'($urandom);
    en = 1'b1;
    ps = ada_sck;
    pw = ada_ws;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (ps && !ada_sck) falls++;
      if (!ps && ada_sck) begin
        if (last_rise >= 0) begin
          n_checks++;
          if (cyc - last_rise != 2 * CLK_DIV) begin
            n_fail++;
            $display("FAIL sck_period: got %0d expected %0d", cyc - last_rise, 2 * CLK_DIV);
          end
        end
        last_rise = cyc;
      end
      if (ada_ws !== pw) begin
        n_checks++;
        if (!(ps === 1'b1 && ada_sck === 1'b0)) begin
          n_fail++;
          $display("FAIL ws_on_fall: ws changed with sck %b->%b expected 1->0", ps, ada_sck);
        end
        n_checks++;
        if (falls != 32) begin
          n_fail++;
          $display("FAIL ws_slot_len: got %0d sck falls expected 32", falls);
        end
        falls = 0;
      end
      n_checks++;
      if (ada_lrs !== 1'b0) begin
        n_fail++;
        $display("FAIL lrs_const: got %b expected 0", ada_lrs);
      end
      ps = ada_sck;
      pw = ada_ws;
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_stream();
    int start = got_q.size();
    int base = word_idx;
    int n;
    left_words[base % 64] = 18'h2A5A3;
    for (int k = 1; k < 4; k++) left_words[(base + k) % 64] = DATA_W'($urandom);
    right_word = 18'h15A5C;
    sample_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6000 && got_q.size() < start + 4; i++) @(negedge clk);
    n = got_q.size() - start;
    n_checks++;
    if (n < 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d samples expected 4", n);
    end
    if (n > 4) n = 4;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (got_q[start + k] !== left_words[(base + k) % 64]) begin
        n_fail++;
        $display("FAIL stream_value[%0d]: got %h expected %h", k, got_q[start + k],
                 left_words[(base + k) % 64]);
      end
      if (k > 0) begin
        n_checks++;
        if (got_cyc[start + k] - got_cyc[start + k - 1] != 1024) begin
          n_fail++;
          $display("FAIL stream_interval[%0d]: got %0d expected 1024", k,
                   got_cyc[start + k] - got_cyc[start + k - 1]);
        end
      end
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overrun();
    int base = word_idx;
    left_words[base % 64] = 18'h00001;
    left_words[(base + 1) % 64] = 18'h00002;
    left_words[(base + 2) % 64] = 18'h00003;
    for (int k = 3; k < 8; k++) left_words[(base + k) % 64] = DATA_W'($urandom);
    sample_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 2500 && sample_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || sample !== 18'h00001) begin
      n_fail++;
      $display("FAIL ovr_first: got valid=%b sample=%h expected 1 00001", sample_valid, sample);
    end
    repeat (1023) @(negedge clk);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_early: got %b expected 0", overrun);
    end
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1 || sample !== 18'h00001) begin
      n_fail++;
      $display("FAIL ovr_second: got ovr=%b sample=%h expected 1 00001", overrun, sample);
    end
    repeat (1024) @(negedge clk);
    n_checks++;
    if ({sample_valid, overrun} !== 2'b11 || sample !== 18'h00001) begin
      n_fail++;
      $display("FAIL ovr_third: got valid/ovr=%b sample=%h expected 11 00001",
               {sample_valid, overrun}, sample);
    end
  endtask

  task automatic test_overrun_clr();
    repeat (1023) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_drop: got %b expected 1", overrun);
    end
    repeat (5) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_plain: got %b expected 0", overrun);
    end
    n_checks++;
    if (sample !== 18'h00001) begin
      n_fail++;
      $display("FAIL clr_sample_held: got %h expected 00001", sample);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b0 || sample !== 18'h00001) begin
      n_fail++;
      $display("FAIL drain: got valid=%b sample=%h expected 0 00001", sample_valid, sample);
    end
  endtask

  task automatic test_en_drop();
    int start = got_q.size();
    int base = word_idx;
    logic [DATA_W-1:0] wa, wb;
    bit found = 1'b0;
    wa = DATA_W'($urandom);
    wb = DATA_W'($urandom);
    if (wb == wa) wb = wa ^ 18'h00001;
    left_words[base % 64] = wa;
    left_words[(base + 1) % 64] = wb;
    sample_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (pos == 9 && !slot_right) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL endrop_reach_b9: got timeout expected left bit 9");
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ada_sck, ada_ws} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_lines: got sck/ws=%b expected 00", {ada_sck, ada_ws});
      end
    end
    n_checks++;
    if (sample_valid !== 1'b0 || got_q.size() != start) begin
      n_fail++;
      $display("FAIL endrop_partial: got valid=%b samples=%0d expected 0 0", sample_valid,
               got_q.size() - start);
    end
    en = 1'b1;
    for (int i = 0; i < 2500 && got_q.size() <= start; i++) @(negedge clk);
    n_checks++;
    if (got_q.size() <= start) begin
      n_fail++;
      $display("FAIL endrop_next: got no sample expected %h", wb);
    end else if (got_q[start] !== wb) begin
      n_fail++;
      $display("FAIL endrop_next: got %h expected %h", got_q[start], wb);
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base = word_idx;
    logic [DATA_W-1:0] wc, wd;
    wc = DATA_W'($urandom);
    wd = DATA_W'($urandom);
    if (wd == wc) wd = wc ^ 18'h00001;
    left_words[base % 64] = wc;
    left_words[(base + 1) % 64] = wd;
    sample_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 1500 && sample_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || sample !== wc) begin
      n_fail++;
      $display("FAIL rstmid_pre: got valid=%b sample=%h expected 1 %h", sample_valid, sample, wc);
    end
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ada_sck, ada_ws, ada_lrs, sample_valid, overrun} !== 5'b00000 || sample !== 18'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got sck/ws/lrs/valid/ovr=%b sample=%h expected 00000 00000",
               {ada_sck, ada_ws, ada_lrs, sample_valid, overrun}, sample);
    end
    for (int i = 0; i < 2000 && sample_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || sample !== wd) begin
      n_fail++;
      $display("FAIL rstmid_after: got valid=%b sample=%h expected 1 %h", sample_valid, sample, wd);
    end
    sample_ready = 1'b1;
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_stream();
    test_overrun();
    test_overrun_clr();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation time limit expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 Parameter CLK_DIV, default 8: clk cycles per ada_sck half-period; legal range 4..255.
REQ-002 Parameter DATA_W, default 18: significant MSB-first bits captured per left slot.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: system clock; every flop is on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port en, input, 1: capture enable; low holds the serial interface idle.
REQ-007 Port ada_sck, output, 1: I2S bit clock, registered.
REQ-008 Port ada_ws, output, 1: I2S word select, registered, low selects the left slot.
REQ-009 Port ada_sd, input, 1: mic serial data, asynchronous to clk.
REQ-010 Port ada_lrs, output, 1: mic channel select, constant 0 so the mic drives the left slot.
REQ-011 Port sample, output, DATA_W: signed two's-complement sample in the holding register.
REQ-012 Port sample_valid, output, 1: holding register contains an unconsumed sample.
REQ-013 Port sample_ready, input, 1: consumer accepts the sample in any cycle where sample_valid=1 and sample_ready=1.
REQ-014 Port overrun, output, 1: sticky flag, a completed sample was dropped.
REQ-015 Port overrun_clr, input, 1: single-cycle clear of overrun.

Function
REQ-016 Divider: a counter 0..CLK_DIV-1 toggles ada_sck when it reaches CLK_DIV-1, so the ada_sck period is 2*CLK_DIV clk cycles.
REQ-017 ada_sd passes through a 2-flop synchronizer before any use.
REQ-018 Bit counter b (0..63, wraps 63->0) advances on every ada_sck falling edge; b=0..31 is the left slot and b=32..63 is the right slot.
REQ-019 ada_ws is 1 for b=31..62 and 0 otherwise, so ws changes one bit before each slot MSB, as I2S requires.
REQ-020 The synchronized sd is sampled in the last clk cycle of each ada_sck high phase.
REQ-021 Left slot bits b=0..DATA_W-1 shift into a shift register MSB first; right-slot bits and left bits b>=DATA_W are ignored.
REQ-022 One clk after bit DATA_W-1 is sampled, the sample is complete and a load is attempted into the holding register.
REQ-023 Load when sample_valid=0, or when sample_valid=1 and sample_ready=1 in the same cycle: sample is updated and sample_valid=1.
REQ-024 Load when sample_valid=1 and sample_ready=0: the new sample is discarded, the held sample is unchanged, and overrun is set.
REQ-025 sample_valid=1 and sample_ready=1 with no load clears sample_valid the next cycle; sample keeps its value.
REQ-026 overrun_clr clears overrun; if set and clear occur in the same cycle, set wins.
REQ-027 States are IDLE and RUN; IDLE->RUN on en=1; RUN->IDLE on en=0, effective the next clk.
REQ-028 IDLE: ada_sck=0, ada_ws=0, divider=0, b=63, shift register cleared; a partial sample is discarded.
REQ-029 Entering RUN starts at b=63 with sck low, so the first ws-low bit precedes left MSB b=0.
REQ-030 The holding register, sample_valid and overrun are unaffected by en.

Reset
REQ-031 rst forces IDLE: ada_sck=0, ada_ws=0, ada_lrs=0, sample=0, sample_valid=0, overrun=0, divider=0, b=63, synchronizer flops=0.
REQ-032 Reset asserted mid-frame aborts the frame; the first sample after reset comes from the first complete left slot after en=1.

Structure
REQ-033 Shared package holds SLOT_BITS=32, FRAME_BITS=64, the default DATA_W=18, and the state encoding IDLE/RUN.
REQ-034 One sub-module, i2s_sck_gen, contains the divider and ada_sck, and emits single-cycle sck_rise_last (end of high phase) and sck_fall strobes.

Verification
REQ-035 Scenario: CLK_DIV=8, en=1, mic model drives left value 0x2A5A3 and right value 0x15A5C, sample_ready=1 -> sample=0x2A5A3 and sample_valid pulses once per 1024 clk; the right value never appears.
REQ-036 Scenario: sample_ready=0 for 3 frames with left values 0x00001, 0x00002, 0x00003 -> sample=0x00001; overrun=1 after the second frame.
REQ-037 Scenario: overrun_clr pulsed in the same cycle as a new drop -> overrun stays 1; a pulse with no drop -> overrun=0 next cycle.
REQ-038 Scenario: en dropped at b=9 of the left slot, then raised -> no sample from the partial frame; the next full frame's value is delivered; ada_sck=0 and ada_ws=0 while idle.
REQ-039 Scenario: rst asserted for 1 clk mid-frame with sample_valid=1 -> all outputs equal the REQ-031 values on the next clk.
REQ-040 Scenario: waveform check -> ada_sck period is 16 clk; ada_ws toggles only on ada_sck falling edges, one bit before the MSB; ada_lrs=0 throughout.
